// File: rtl/nios_div_pkg.sv
// Shared types, widths and special-case constants for the Nios II iterative divider.
package nios_div_pkg;

  localparam int DIV_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [DIV_DATA_W-1:0] DIV0_QUOT     = {DIV_DATA_W{1'b1}};
  localparam logic [DIV_DATA_W-1:0] SOVF_QUOT     = {1'b1, {(DIV_DATA_W-1){1'b0}}};
  localparam logic [DIV_DATA_W-1:0] SOVF_DIVIDEND = {1'b1, {(DIV_DATA_W-1){1'b0}}};
  localparam logic [DIV_DATA_W-1:0] SOVF_DIVISOR  = {DIV_DATA_W{1'b1}};

  function automatic logic [DIV_DATA_W-1:0] twos_neg(input logic [DIV_DATA_W-1:0] v);
    return ~v + DIV_DATA_W'(1);
  endfunction

  // Magnitude of an operand: absolute value in signed mode, raw bits otherwise.
  function automatic logic [DIV_DATA_W-1:0] mag(input logic [DIV_DATA_W-1:0] v,
                                                input logic                  is_signed);
    if (is_signed && v[DIV_DATA_W-1]) begin
      return twos_neg(v);
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/nios_div_cell_if.sv
// Pipeline-side start/busy/done handshake and operand/result bus of the divider.
interface nios_div_cell_if #(parameter int DATA_W = nios_div_pkg::DIV_DATA_W);
  logic              D_start;
  logic              D_signed;
  logic [DATA_W-1:0] D_src1;
  logic [DATA_W-1:0] D_src2;
  logic              D_abort;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;

  modport master (output D_start, D_signed, D_src1, D_src2, D_abort,
                  input  busy, done, quotient, remainder);
  modport slave  (input  D_start, D_signed, D_src1, D_src2, D_abort,
                  output busy, done, quotient, remainder);
endinterface

// File: rtl/nios_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module nios_div_step
  import nios_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic [DATA_W:0]   rem_i,
  input  logic              bit_i,
  input  logic [DATA_W-1:0] dsr_i,
  output logic [DATA_W:0]   rem_o,
  output logic              qbit_o
);

  logic [DATA_W+1:0] shifted_s;
  logic [DATA_W+1:0] trial_s;

  // One extra guard bit so the borrow of the trial subtraction is its sign bit.
  always_comb begin
    shifted_s = {rem_i, bit_i};
    trial_s   = shifted_s - {2'b00, dsr_i};
    if (!trial_s[DATA_W+1]) begin
      rem_o  = trial_s[DATA_W:0];
      qbit_o = 1'b1;
    end else begin
      rem_o  = shifted_s[DATA_W:0];
      qbit_o = 1'b0;
    end
  end

endmodule

// File: rtl/nios_div_cell.sv
// Iterative signed/unsigned divider: PREP -> DATA_W restoring steps -> sign FIX -> DONE pulse.
module nios_div_cell
  import nios_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic            clk,
  input  logic            reset_n,
  nios_div_cell_if.slave  bus
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic [DATA_W-1:0] dsr_q, dsr_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] remo_q, remo_d;
  logic              sgn_q, sgn_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W:0]   step_rem_s;
  logic              step_qbit_s;

  // dvd_q doubles as the dividend shift register and the quotient accumulator.
  nios_div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i  (rem_q),
    .bit_i  (dvd_q[DATA_W-1]),
    .dsr_i  (dsr_q),
    .rem_o  (step_rem_s),
    .qbit_o (step_qbit_s)
  );

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.D_start && !bus.D_abort) begin
          dvd_d   = bus.D_src1;
          dsr_d   = bus.D_src2;
          sgn_d   = bus.D_signed;
          state_d = ST_PREP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREP: begin
        qneg_d = sgn_q & (dvd_q[DATA_W-1] ^ dsr_q[DATA_W-1]);
        rneg_d = sgn_q & dvd_q[DATA_W-1];
        if (dsr_q == {DATA_W{1'b0}}) begin
          quot_d  = DIV0_QUOT;
          remo_d  = dvd_q;
          state_d = ST_DONE;
        end else if (sgn_q && (dvd_q == SOVF_DIVIDEND) && (dsr_q == SOVF_DIVISOR)) begin
          quot_d  = SOVF_QUOT;
          remo_d  = {DATA_W{1'b0}};
          state_d = ST_DONE;
        end else begin
          rem_d   = {(DATA_W+1){1'b0}};
          dvd_d   = mag(dvd_q, sgn_q);
          dsr_d   = mag(dsr_q, sgn_q);
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        rem_d = step_rem_s;
        dvd_d = {dvd_q[DATA_W-2:0], step_qbit_s};
        if (cnt_q == LAST_CNT) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FIX: begin
        quot_d  = qneg_q ? twos_neg(dvd_q) : dvd_q;
        remo_d  = rneg_q ? twos_neg(rem_q[DATA_W-1:0]) : rem_q[DATA_W-1:0];
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A flush leaves the previously published result untouched; DONE already committed.
    if (bus.D_abort && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      state_d = ST_IDLE;
      quot_d  = quot_q;
      remo_d  = remo_q;
    end else begin
      state_d = state_d;
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, working and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      rem_q   <= {(DATA_W+1){1'b0}};
      dvd_q   <= {DATA_W{1'b0}};
      dsr_q   <= {DATA_W{1'b0}};
      quot_q  <= {DATA_W{1'b0}};
      remo_q  <= {DATA_W{1'b0}};
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = remo_q;

endmodule

// File: tb/tb_nios_div_cell.sv
// Bench for nios_div_cell: cycle-count reference model, directed literal cases, random traffic.
module tb_nios_div_cell;
  import nios_div_pkg::*;

  localparam int W = DIV_DATA_W;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  nios_div_cell_if #(.DATA_W(W)) bus ();
  nios_div_cell #(.DATA_W(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  function automatic logic [2*W-1:0] ref_qr(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    if (b == 32'h0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
    return 35;
  endfunction

  // Reference model: m_c counts cycles since acceptance; done when it reaches the latency.
  logic         m_active, m_done;
  int           m_c, m_lat;
  logic [W-1:0] m_q, m_r, p_q, p_r;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active <= 1'b0; m_done <= 1'b0; m_c <= 0; m_lat <= 0;
      m_q <= 32'h0; m_r <= 32'h0; p_q <= 32'h0; p_r <= 32'h0;
    end else if (m_active) begin
      if (m_c == m_lat || bus.D_abort) begin
        m_active <= 1'b0;
        m_done   <= 1'b0;
      end else begin
        m_c    <= m_c + 1;
        m_done <= (m_c + 1 == m_lat);
        if (m_c + 1 == m_lat) begin
          m_q <= p_q;
          m_r <= p_r;
        end
      end
    end else if (bus.D_start && !bus.D_abort) begin
      {p_q, p_r} <= ref_qr(bus.D_src1, bus.D_src2, bus.D_signed);
      m_lat      <= ref_lat(bus.D_src1, bus.D_src2, bus.D_signed);
      m_active   <= 1'b1;
      m_c        <= 1;
      m_done     <= 1'b0;
    end else begin
      m_done <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and compare all outputs against the model.
  task automatic step();
    @(negedge clk);
    cyc++;
    chk("busy", {31'h0, bus.busy}, {31'h0, m_active});
    chk("done", {31'h0, bus.done}, {31'h0, m_done});
    chk("quotient", bus.quotient, m_q);
    chk("remainder", bus.remainder, m_r);
  endtask

  task automatic run_dir(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] eq, input logic [31:0] er,
                         input int elat, input int abort_at, input bit poke);
    int dk = -1;
    bus.D_src1 = a; bus.D_src2 = b; bus.D_signed = s;
    bus.D_start = 1'b1; bus.D_abort = 1'b0;
    for (int k = 1; k <= 60 && dk < 0; k++) begin
      step();
      if (k == 1) chk({name, " busy@1"}, {31'h0, bus.busy}, 32'h1);
      bus.D_start = poke && (k == 5);
      if (poke && k == 5) begin
        bus.D_src1 = 32'd999; bus.D_src2 = 32'd3; bus.D_signed = ~s;
      end
      bus.D_abort = (k == abort_at);
      if (bus.done) begin
        dk = k;
        chk({name, " q"}, bus.quotient, eq);
        chk({name, " r"}, bus.remainder, er);
      end
    end
    chk({name, " latency"}, dk, elat);
    step();
    chk({name, " idle"}, {31'h0, bus.busy}, 32'h0);
    bus.D_abort = 1'b0; bus.D_start = 1'b0;
  endtask

  function automatic logic [31:0] pick_a();
    case ($urandom_range(5))
      0: return 32'h8000_0000;
      1: return $urandom_range(20);
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] pick_b();
    case ($urandom_range(6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return $urandom_range(20, 1);
      3: return 32'h1;
      default: return $urandom >> $urandom_range(31);
    endcase
  endfunction

  initial begin
    reset_n = 1'b0;
    bus.D_start = 1'b0; bus.D_signed = 1'b0; bus.D_abort = 1'b0;
    bus.D_src1 = 32'h0; bus.D_src2 = 32'h0;
    step();
    chk("reset busy", {31'h0, bus.busy}, 32'h0);
    chk("reset done", {31'h0, bus.done}, 32'h0);
    chk("reset q", bus.quotient, 32'h0);
    chk("reset r", bus.remainder, 32'h0);
    step();
    reset_n = 1'b1;
    step();

    run_dir("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 35, -1, 1'b1);
    run_dir("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 35, -1, 1'b0);
    run_dir("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 35, -1, 1'b0);
    run_dir("uFF_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'h0, 35, -1, 1'b0);
    run_dir("u_div0", 32'h1234_5678, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 2, -1, 1'b0);
    run_dir("s_div0", 32'h1234_5678, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 2, -1, 1'b0);
    run_dir("s_neg_div0", 32'hF000_0000, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hF000_0000, 2, -1, 1'b0);
    run_dir("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 2, -1, 1'b0);
    run_dir("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000, 35, -1, 1'b0);
    run_dir("abort_in_done", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 35, 35, 1'b0);

    // Abort mid-iteration: no done, prior result (14, 2) held, restart lands in cycle 47.
    begin
      bit saw_done = 1'b0;
      bus.D_src1 = 32'd1000; bus.D_src2 = 32'd3; bus.D_signed = 1'b0; bus.D_start = 1'b1;
      for (int k = 1; k <= 11; k++) begin
        step();
        bus.D_start = 1'b0;
        bus.D_abort = (k == 10);
        if (bus.done) saw_done = 1'b1;
      end
      chk("abort busy@11", {31'h0, bus.busy}, 32'h0);
      chk("abort no done", {31'h0, saw_done}, 32'h0);
      chk("abort q held", bus.quotient, 32'd14);
      chk("abort r held", bus.remainder, 32'd2);
      bus.D_abort = 1'b0;
      step();
      run_dir("restart", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 35, -1, 1'b0);
    end

    // Abort and start together in IDLE: start is dropped.
    bus.D_start = 1'b1; bus.D_abort = 1'b1;
    step();
    chk("abort_start busy", {31'h0, bus.busy}, 32'h0);
    bus.D_start = 1'b0; bus.D_abort = 1'b0;
    step();

    // Asynchronous reset during the iteration phase.
    bus.D_src1 = 32'd100; bus.D_src2 = 32'd7; bus.D_signed = 1'b0; bus.D_start = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      bus.D_start = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    chk("async rst busy", {31'h0, bus.busy}, 32'h0);
    chk("async rst done", {31'h0, bus.done}, 32'h0);
    chk("async rst q", bus.quotient, 32'h0);
    chk("async rst r", bus.remainder, 32'h0);
    step();
    step();
    reset_n = 1'b1;
    step();
    run_dir("post_rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 35, -1, 1'b0);

    // Random traffic: starts, operand churn while busy, occasional flushes.
    for (int i = 0; i < 6000; i++) begin
      step();
      bus.D_start  = ($urandom_range(3) == 0);
      bus.D_signed = $urandom_range(1) == 1;
      bus.D_src1   = pick_a();
      bus.D_src2   = pick_b();
      bus.D_abort  = ($urandom_range(99) == 0);
    end
    bus.D_start = 1'b0; bus.D_abort = 1'b0;
    for (int i = 0; i < 40; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
